// File: rtl/mem_burst_pkg.sv
// Shared burst-port constants for the memory read/write arbiters.
// State encodings are common to mem_read_arbi and mem_write_arbi.
package mem_burst_pkg;

  localparam int DEF_MEM_DATA_BITS = 64;
  localparam int DEF_ADDR_BITS     = 24;
  localparam int DEF_LEN_BITS      = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Last-grant pointer after reset, so ch0 wins first.
  localparam logic [1:0] LAST_RST = 2'd2;

endpackage

// File: rtl/rr_arb3.sv
// Three-way combinational round-robin pick.
// Searches from the channel after last, wrapping 0,1,2.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);

  always_comb begin
    gnt = 2'd0;
    unique case (last)
      2'd0: gnt = req[1] ? 2'd1 :
                  req[2] ? 2'd2 : 2'd0;
      2'd1: gnt = req[2] ? 2'd2 :
                  req[0] ? 2'd0 : 2'd1;
      default: gnt = req[0] ? 2'd0 :
                     req[1] ? 2'd1 : 2'd2;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/mem_read_arbi.sv
// Round-robin arbiter of three burst readers onto one
// mem_burst_v2 read port; whole bursts, routed returns.
module mem_read_arbi
  import mem_burst_pkg::*;
#(
  parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int LEN_BITS      = DEF_LEN_BITS
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     ch0_rd_burst_req,
  input  logic [LEN_BITS-1:0]      ch0_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     ch0_rd_burst_addr,
  output logic                     ch0_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] ch0_rd_burst_data,
  output logic                     ch0_rd_burst_finish,
  input  logic                     ch1_rd_burst_req,
  input  logic [LEN_BITS-1:0]      ch1_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     ch1_rd_burst_addr,
  output logic                     ch1_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] ch1_rd_burst_data,
  output logic                     ch1_rd_burst_finish,
  input  logic                     ch2_rd_burst_req,
  input  logic [LEN_BITS-1:0]      ch2_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     ch2_rd_burst_addr,
  output logic                     ch2_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] ch2_rd_burst_data,
  output logic                     ch2_rd_burst_finish,
  output logic                     rd_burst_req,
  output logic [LEN_BITS-1:0]      rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic [1:0]               grant_ch,
  output logic                     busy
);

  logic [1:0]           state;
  logic [1:0]           last;
  logic [1:0]           grant_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] addr_q;

  logic [2:0]           req;
  logic [1:0]           pick;
  logic                 any;
  logic [LEN_BITS-1:0]  len_sel;
  logic [ADDR_BITS-1:0] addr_sel;
  logic [2:0]           sel;

  assign req = {ch2_rd_burst_req,
                ch1_rd_burst_req,
                ch0_rd_burst_req};

  rr_arb3 u_arb (
    .req  (req),
    .last (last),
    .gnt  (pick),
    .any  (any)
  );

  always_comb begin
    len_sel  = ch0_rd_burst_len;
    addr_sel = ch0_rd_burst_addr;
    unique case (pick)
      2'd1: begin
        len_sel  = ch1_rd_burst_len;
        addr_sel = ch1_rd_burst_addr;
      end
      2'd2: begin
        len_sel  = ch2_rd_burst_len;
        addr_sel = ch2_rd_burst_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= LAST_RST;
      grant_q <= 2'd0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            grant_q <= pick;
            last    <= pick;
            len_q   <= len_sel;
            addr_q  <= addr_sel;
            state   <= ST_BUSY;
          end
        end
        // The burst cannot be aborted; only finish ends it.
        ST_BUSY: begin
          if (rd_burst_finish)
            state <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state == ST_BUSY);
  assign rd_burst_req  = busy;
  assign rd_burst_len  = len_q;
  assign rd_burst_addr = addr_q;
  assign grant_ch      = grant_q;

  assign sel = busy ? (3'b001 << grant_q) : 3'b000;

  assign ch0_rd_burst_data_valid = sel[0] & rd_burst_data_valid;
  assign ch1_rd_burst_data_valid = sel[1] & rd_burst_data_valid;
  assign ch2_rd_burst_data_valid = sel[2] & rd_burst_data_valid;

  assign ch0_rd_burst_finish = sel[0] & rd_burst_finish;
  assign ch1_rd_burst_finish = sel[1] & rd_burst_finish;
  assign ch2_rd_burst_finish = sel[2] & rd_burst_finish;

  assign ch0_rd_burst_data = rd_burst_data;
  assign ch1_rd_burst_data = rd_burst_data;
  assign ch2_rd_burst_data = rd_burst_data;

endmodule

// File: tb/tb_mem_read_arbi.sv
// Bench for mem_read_arbi: burst-level reference model,
// memory responder, directed tables and random traffic.
module tb_mem_read_arbi;

  localparam int DW = 64;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int VW = 236;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [LW-1:0] len [3];
  logic [AW-1:0] addr [3];
  logic          rd_valid = 1'b0;
  logic          rd_fin = 1'b0;
  logic [DW-1:0] rd_data = '0;

  logic          c0_v, c1_v, c2_v;
  logic          c0_f, c1_f, c2_f;
  logic [DW-1:0] c0_d, c1_d, c2_d;
  logic          rd_req;
  logic [LW-1:0] rd_len;
  logic [AW-1:0] rd_addr;
  logic [1:0]    grant_ch;
  logic          busy;

  mem_read_arbi dut (
    .mem_clk                 (mem_clk),
    .rst                     (rst),
    .ch0_rd_burst_req        (req[0]),
    .ch0_rd_burst_len        (len[0]),
    .ch0_rd_burst_addr       (addr[0]),
    .ch0_rd_burst_data_valid (c0_v),
    .ch0_rd_burst_data       (c0_d),
    .ch0_rd_burst_finish     (c0_f),
    .ch1_rd_burst_req        (req[1]),
    .ch1_rd_burst_len        (len[1]),
    .ch1_rd_burst_addr       (addr[1]),
    .ch1_rd_burst_data_valid (c1_v),
    .ch1_rd_burst_data       (c1_d),
    .ch1_rd_burst_finish     (c1_f),
    .ch2_rd_burst_req        (req[2]),
    .ch2_rd_burst_len        (len[2]),
    .ch2_rd_burst_addr       (addr[2]),
    .ch2_rd_burst_data_valid (c2_v),
    .ch2_rd_burst_data       (c2_d),
    .ch2_rd_burst_finish     (c2_f),
    .rd_burst_req            (rd_req),
    .rd_burst_len            (rd_len),
    .rd_burst_addr           (rd_addr),
    .rd_burst_data_valid     (rd_valid),
    .rd_burst_data           (rd_data),
    .rd_burst_finish         (rd_fin),
    .grant_ch                (grant_ch),
    .busy                    (busy)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model: phase 0 idle, 1 bursting, 2 gap.
  int            m_phase, m_gnt, m_last;
  logic [LW-1:0] m_len;
  logic [AW-1:0] m_addr;

  // Memory responder state.
  int r_st = 0, r_left = 0, r_dly = 0, r_fl = 0;
  bit stray_en = 0, gap_en = 1;

  // Requester behaviour and observations.
  bit auto_drop [3];
  bit fin_seen [3];
  int vcnt [3], fcnt [3], wait_cnt [3];
  int glog [$];
  int gaps [$];
  int gap_run = 0;
  bit had_burst = 0;
  bit prev_busy = 0, prev_req = 0;

  typedef struct {
    logic [2:0]      mask;
    int              n;
    logic [2:0][1:0] g;
  } vec_t;
  vec_t tbl [5];

  function automatic int rr_pick(logic [2:0] r, int lst);
    for (int k = 1; k <= 3; k++)
      if (r[(lst + k) % 3]) return (lst + k) % 3;
    return -1;
  endfunction

  task automatic chk_int(string nm, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_vec(string nm, logic [VW-1:0] a,
                         logic [VW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h",
               nm, $time, a, e);
    end
  endtask

  task automatic model_step();
    int p;
    if (rst) begin
      m_phase = 0; m_gnt = 0; m_last = 2;
      m_len = '0; m_addr = '0;
    end else if (m_phase == 0) begin
      p = rr_pick(req, m_last);
      if (p >= 0) begin
        m_gnt = p; m_last = p;
        m_len = len[p]; m_addr = addr[p];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (rd_fin) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic responder();
    rd_valid = 1'b0;
    rd_fin   = 1'b0;
    if (rst) begin
      rd_data = '0;
      r_st = 0;
      return;
    end
    rd_data = {$urandom, $urandom};
    if (r_st == 0) begin
      if (rd_req) begin
        r_left = int'(rd_len);
        r_dly  = $urandom_range(0, 2);
        r_fl   = $urandom_range(0, 1);
        r_st   = 1;
      end else if (stray_en) begin
        rd_valid = 1'($urandom_range(0, 1));
        rd_fin   = 1'($urandom_range(0, 1));
      end
    end
    if (r_st == 1) begin
      if (r_dly > 0) r_dly--;
      else r_st = 2;
    end
    if (r_st == 2) begin
      if (r_left == 0) begin
        rd_fin = 1'b1; r_st = 4;
      end else if (!gap_en || $urandom_range(0, 3) != 0) begin
        rd_valid = 1'b1;
        r_left--;
        if (r_left == 0) begin
          if (r_fl != 0) begin rd_fin = 1'b1; r_st = 4; end
          else r_st = 3;
        end
      end
    end else if (r_st == 3) begin
      rd_fin = 1'b1; r_st = 4;
    end else if (r_st == 4) begin
      if (!rd_req) r_st = 0;
    end
  endtask

  task automatic monitor();
    logic [2:0] v, f;
    v = {c2_v, c1_v, c0_v};
    f = {c2_f, c1_f, c0_f};
    for (int n = 0; n < 3; n++) begin
      vcnt[n] += int'(v[n]);
      fcnt[n] += int'(f[n]);
      if (f[n]) fin_seen[n] = 1;
    end
    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_ch));
      chk_int("starvation", int'(wait_cnt[grant_ch] <= 2), 1);
      for (int n = 0; n < 3; n++) begin
        if (n == int'(grant_ch)) wait_cnt[n] = 0;
        else if (req[n]) wait_cnt[n]++;
      end
    end
    for (int n = 0; n < 3; n++)
      if (!req[n]) wait_cnt[n] = 0;
    if (rst) begin
      had_burst = 0; gap_run = 0;
    end else if (!rd_req) begin
      gap_run++;
    end else begin
      if (!prev_req && had_burst) gaps.push_back(gap_run);
      had_burst = 1;
      gap_run = 0;
    end
    prev_busy = busy;
    prev_req  = rd_req;
  endtask

  function automatic logic [VW-1:0] act_vec();
    return {rd_req, busy, grant_ch, rd_len, rd_addr,
            c2_v, c1_v, c0_v, c2_f, c1_f, c0_f,
            c2_d, c1_d, c0_d};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic       eb;
    logic [2:0] ev, ef;
    eb = (m_phase == 1);
    for (int n = 0; n < 3; n++) begin
      ev[n] = eb && (m_gnt == n) && rd_valid;
      ef[n] = eb && (m_gnt == n) && rd_fin;
    end
    return {eb, eb, 2'(m_gnt), m_len, m_addr,
            ev, ef, rd_data, rd_data, rd_data};
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    model_step();
    #1;
    for (int n = 0; n < 3; n++)
      if (fin_seen[n]) begin
        if (auto_drop[n]) req[n] = 1'b0;
        fin_seen[n] = 0;
      end
    responder();
    @(negedge mem_clk);
    if (chk_en) chk_vec("cycle", act_vec(), exp_vec());
    monitor();
  endtask

  task automatic clear_obs();
    for (int n = 0; n < 3; n++) begin
      vcnt[n] = 0; fcnt[n] = 0; fin_seen[n] = 0;
      wait_cnt[n] = 0; auto_drop[n] = 1;
    end
    glog.delete();
    gaps.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic run_idle(string nm, int max);
    int n = 0;
    while ((req != 0 || busy || r_st != 0) && n < max) begin
      tick();
      n++;
    end
    chk_int({nm, "_timeout"}, int'(n >= max), 0);
    repeat (3) tick();
  endtask

  task automatic wait_vcnt(string nm, int ch, int cnt);
    int n = 0;
    while (vcnt[ch] < cnt && n < 400) begin
      tick();
      n++;
    end
    chk_int({nm, "_timeout"}, int'(n >= 400), 0);
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      len[n] = '0; addr[n] = '0;
    end
    tbl[0] = '{3'b111, 3, {2'd2, 2'd1, 2'd0}};
    tbl[1] = '{3'b110, 2, {2'd0, 2'd2, 2'd1}};
    tbl[2] = '{3'b101, 2, {2'd0, 2'd2, 2'd0}};
    tbl[3] = '{3'b011, 2, {2'd0, 2'd1, 2'd0}};
    tbl[4] = '{3'b100, 1, {2'd0, 2'd0, 2'd2}};

    // Reset state
    do_reset();
    chk_vec("reset_zero", act_vec(), '0);

    // ch1 alone: latency, forwarding and routing
    len[1] = 10'd16; addr[1] = 24'h001000;
    req = 3'b010;
    chk_int("t1_req_before", int'(rd_req), 0);
    tick();
    chk_int("t1_req_lat1", int'(rd_req), 1);
    chk_int("t1_len", int'(rd_len), 16);
    chk_int("t1_addr", int'(rd_addr), 'h1000);
    run_idle("t1", 200);
    chk_int("t1_ch1_valids", vcnt[1], 16);
    chk_int("t1_other_valids", vcnt[0] + vcnt[2], 0);
    chk_int("t1_ch1_finish", fcnt[1], 1);
    chk_int("t1_other_finish", fcnt[0] + fcnt[2], 0);

    // Simultaneous-request table from reset
    foreach (tbl[i]) begin
      do_reset();
      for (int n = 0; n < 3; n++) begin
        len[n]  = LW'(4 + n);
        addr[n] = AW'(24'h100000 * (n + 1) + i);
      end
      req = tbl[i].mask;
      run_idle($sformatf("tbl%0d", i), 400);
      chk_int($sformatf("tbl%0d_bursts", i), glog.size(), tbl[i].n);
      for (int j = 0; j < tbl[i].n && j < glog.size(); j++)
        chk_int($sformatf("tbl%0d_grant%0d", i, j),
                glog[j], int'(tbl[i].g[j]));
      chk_int($sformatf("tbl%0d_gapcnt", i), gaps.size(),
              tbl[i].n - 1);
      foreach (gaps[j])
        chk_int($sformatf("tbl%0d_gap%0d", i, j), gaps[j], 2);
    end

    // ch0 re-requests at once while ch2 waits
    do_reset();
    len[0] = 10'd6; len[2] = 10'd6;
    addr[0] = 24'h0a0000; addr[2] = 24'h0c0000;
    auto_drop[0] = 0;
    req = 3'b101;
    while (fcnt[0] == 0 && glog.size() < 4) tick();
    fin_seen[0] = 0;
    auto_drop[0] = 1;
    run_idle("t3", 400);
    chk_int("t3_bursts", glog.size(), 3);
    if (glog.size() == 3) begin
      chk_int("t3_g0", glog[0], 0);
      chk_int("t3_g1", glog[1], 2);
      chk_int("t3_g2", glog[2], 0);
    end

    // ch2 drops req mid-burst
    do_reset();
    len[2] = 10'd32; addr[2] = 24'hfedcba;
    req = 3'b100;
    wait_vcnt("t4", 2, 5);
    req[2] = 1'b0;
    run_idle("t4", 400);
    repeat (5) tick();
    chk_int("t4_valids", vcnt[2], 32);
    chk_int("t4_finish", fcnt[2], 1);
    chk_int("t4_no_regrant", glog.size(), 1);

    // Stray responses while idle
    do_reset();
    stray_en = 1;
    repeat (30) tick();
    stray_en = 0;
    chk_int("t5_no_grant", glog.size(), 0);
    chk_int("t5_valids", vcnt[0] + vcnt[1] + vcnt[2], 0);
    chk_int("t5_finish", fcnt[0] + fcnt[1] + fcnt[2], 0);
    chk_int("t5_busy", int'(busy), 0);

    // Reset in the middle of a ch0 burst
    do_reset();
    len[0] = 10'd64; addr[0] = 24'h123456;
    req = 3'b001;
    wait_vcnt("t6", 0, 8);
    rst = 1'b1;
    tick();
    chk_vec("t6_zero", act_vec(), '0);
    req = 3'b000;
    tick();
    rst = 1'b0;
    clear_obs();
    len[0] = 10'd3; len[1] = 10'd3;
    req = 3'b011;
    run_idle("t6", 200);
    chk_int("t6_bursts", glog.size(), 2);
    if (glog.size() == 2) begin
      chk_int("t6_first", glog[0], 0);
      chk_int("t6_second", glog[1], 1);
    end

    // Random traffic against the model
    do_reset();
    stray_en = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 3; n++)
        if (!req[n] && $urandom_range(0, 5) == 0) begin
          len[n]  = LW'($urandom_range(0, 12));
          addr[n] = AW'($urandom);
          req[n]  = 1'b1;
        end
      tick();
    end
    stray_en = 0;
    run_idle("rand", 400);
    chk_int("rand_some_bursts", int'(glog.size() > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
